// File: rtl/barrido_display_if.sv
// Segment/digit bus between the display encoders and the four-digit scan driver.
interface barrido_display_if;
  logic [6:0] display0;
  logic [6:0] display1;
  logic [6:0] display2;
  logic [6:0] display3;
  logic [3:0] habilitar;
  logic [3:0] digito;
  logic [6:0] segmentos;

  modport master (
    output display0, display1, display2, display3, habilitar,
    input  digito, segmentos
  );

  modport slave (
    input  display0, display1, display2, display3, habilitar,
    output digito, segmentos
  );
endinterface

// File: rtl/barrido_display.sv
// Four-digit seven-segment scan driver: prescaled slots, leading blank interval,
// and skipping of digits whose enable bit is clear.
module barrido_display #(
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter logic [6:0]  SEG_OFF      = 7'b1111111
) (
  input logic               Clock,
  input logic               Reset,
  barrido_display_if.slave  bus
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_next_c;
  logic          last_c;
  logic          show_c;
  logic [6:0]    pattern_c;
  logic [3:0]    digito_q;
  logic [6:0]    segmentos_q;

  assign last_c = (cnt == CW'(PRESCALE - 1));
  assign show_c = (cnt >= CW'(BLANK_CYCLES));

  // Nearest enabled digit after idx; falls back to idx itself, then to a plain step.
  always_comb begin
    logic [1:0] cand;
    idx_next_c = idx + 2'd1;
    cand       = idx;
    if (bus.habilitar[idx]) idx_next_c = idx;
    for (int k = 3; k >= 1; k--) begin
      cand = idx + 2'(k);
      if (bus.habilitar[cand]) idx_next_c = cand;
    end
  end

  always_comb begin
    pattern_c = SEG_OFF;
    case (idx)
      2'd0:    pattern_c = bus.display0;
      2'd1:    pattern_c = bus.display1;
      2'd2:    pattern_c = bus.display2;
      default: pattern_c = bus.display3;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= last_c ? '0 : cnt + CW'(1);
      if (last_c) idx <= idx_next_c;
    end
  end

  // Select and pattern register together so a digit never shows a stale pattern.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      digito_q    <= 4'b1111;
      segmentos_q <= SEG_OFF;
    end else if (show_c && bus.habilitar[idx]) begin
      digito_q    <= ~(4'b0001 << idx);
      segmentos_q <= pattern_c;
    end else begin
      digito_q    <= 4'b1111;
      segmentos_q <= SEG_OFF;
    end
  end

  assign bus.digito    = digito_q;
  assign bus.segmentos = segmentos_q;

endmodule

// File: tb/tb_barrido_display.sv
// Scoreboard bench for barrido_display: the driver predicts each edge's outputs
// from slot arithmetic, a monitor compares them one edge later.
module tb_barrido_display;
  localparam int unsigned P = 8;
  localparam int unsigned B = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] disp [4];
  logic [3:0] hab;

  barrido_display_if bus ();

  assign bus.display0  = disp[0];
  assign bus.display1  = disp[1];
  assign bus.display2  = disp[2];
  assign bus.display3  = disp[3];
  assign bus.habilitar = hab;

  barrido_display #(.PRESCALE(P), .BLANK_CYCLES(B), .SEG_OFF(7'h7F)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [10:0] exp_q [$];
  int checks = 0;
  int passes = 0;
  int pos    = 0;   // cycles into the current slot
  int cur    = 0;   // digit owning the current slot

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic int next_digit(input int from, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(from + k) % 4]) return (from + k) % 4;
    return (from + 1) % 4;
  endfunction

  // Predict the outputs after the coming edge, then advance to the next negedge.
  task automatic step();
    logic [3:0] d;
    logic [6:0] s;
    d = 4'hF;
    s = 7'h7F;
    if (!rst_n) begin
      pos = 0;
      cur = 0;
    end else begin
      if (pos >= int'(B) && hab[cur]) begin
        d = 4'hF;
        d[cur] = 1'b0;
        s = disp[cur];
      end
      if (pos == int'(P) - 1) begin
        pos = 0;
        cur = next_digit(cur, hab);
      end else begin
        pos++;
      end
    end
    exp_q.push_back({d, s});
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int digit, input int at, input string name);
    int n;
    n = 0;
    while (!(cur == digit && pos == at) && n < 200) begin
      step();
      n++;
    end
    check({name, "_reached"}, 32'(n < 200), 32'd1);
  endtask

  // Monitor: compare each edge's outputs against the oldest prediction.
  always @(posedge clk) begin
    logic [10:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("digito", 32'(bus.digito), 32'(e[10:7]));
      check("segmentos", 32'(bus.segmentos), 32'(e[6:0]));
      check("one_hot_select", 32'($countones(~bus.digito) <= 1), 32'd1);
      if (bus.digito == 4'hF) check("dark_segments", 32'(bus.segmentos), 32'h7F);
    end
  end

  initial begin
    rst_n   = 1'b0;
    hab     = 4'b1111;
    disp[0] = 7'h01;
    disp[1] = 7'h4F;
    disp[2] = 7'h12;
    disp[3] = 7'h06;
    run(2);
    rst_n = 1'b1;
    run(40);                       // basic scan, all digits

    hab = 4'b0101;                 // skip mask
    run(48);

    hab = 4'b0000;                 // all dark
    run(40);
    hab = 4'b1000;
    run(40);

    hab = 4'b1111;                 // mid-slot data and mask changes
    run_until(1, 3, "digit1_lit");
    disp[1] = 7'h24;
    run(3);
    hab[1] = 1'b0;
    run(20);
    hab = 4'b1111;
    disp[1] = 7'h4F;
    run(10);

    run_until(2, 5, "digit2_cnt5"); // reset mid-operation
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(40);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) hab = 4'($urandom);
      if ($urandom_range(0, 4) == 0) disp[$urandom_range(0, 3)] = 7'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
